// File: rtl/fp_mem_pkg.sv
// Shared definitions for the float register-memory blocks: controller
// state encoding, IEEE-754 single-precision field positions, default
// memory geometry and the total-order key helper.
package fp_mem_pkg;

  localparam int DEF_AW = 5;   // 32-word float memory
  localparam int DEF_DW = 32;  // IEEE-754 single

  localparam int         EXP_MSB  = 30;
  localparam int         EXP_LSB  = 23;
  localparam int         MAN_W    = 23;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    RD_X,
    RD_Y,
    CAP_Y,
    CMP,
    WR_X,
    WR_Y,
    DONE
  } state_t;

  // Maps a non-NaN float onto an unsigned key with the same ordering:
  // negatives are bit-inverted so larger magnitudes sort lower, and
  // positives get the top bit set so they sort above every negative.
  function automatic logic [31:0] fp_key(input logic [31:0] v);
    return v[31] ? ~v : (v | 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp_order_cmp.sv
// Combinational IEEE-754 single-precision ordering of a against b.
// unordered flags a NaN operand; gt/lt are both low when unordered or
// when the operands are equal (including +0 against -0).
module fp_order_cmp
  import fp_mem_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt,
  output logic        lt,
  output logic        unordered
);

  logic        a_nan;
  logic        b_nan;
  logic        both_zero;
  logic [31:0] key_a;
  logic [31:0] key_b;

  // NaN: all-ones exponent with a non-zero mantissa (infinities excluded).
  assign a_nan = (a[EXP_MSB:EXP_LSB] == EXP_ALL1) && (a[MAN_W-1:0] != '0);
  assign b_nan = (b[EXP_MSB:EXP_LSB] == EXP_ALL1) && (b[MAN_W-1:0] != '0);

  // The keys would order -0 below +0, so signed zeros are tied explicitly.
  assign both_zero = (a[30:0] == '0) && (b[30:0] == '0);

  assign key_a = fp_key(a);
  assign key_b = fp_key(b);

  assign unordered = a_nan | b_nan;
  assign gt        = !unordered && !both_zero && (key_a > key_b);
  assign lt        = !unordered && !both_zero && (key_a < key_b);

endmodule

// File: rtl/fp_cmp_swap_engine.sv
// Compare-and-swap controller for the 32x32 float register memory.
// Reads the words at addr_x and addr_y, and if they are out of order
// writes them back exchanged. Ascending order by default; define
// FP_SWAP_DESCEND_EN to sort descending instead (NaN and signed-zero
// handling are unchanged).
module fp_cmp_swap_engine
  import fp_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] addr_x,
  input  logic [AW-1:0] addr_y,
  output logic          busy,
  output logic          done,
  output logic          swapped,
  output logic          nan_flag,
  output logic [AW-1:0] mem_ra,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_wa,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_x_q;
  logic [AW-1:0] addr_y_q;
  logic [DW-1:0] opx;
  logic [DW-1:0] opy;
  logic          x_gt_y;
  logic          x_lt_y;
  logic          unordered;
  logic          swap_cond;

  fp_order_cmp u_order_cmp (
    .a         (opx),
    .b         (opy),
    .gt        (x_gt_y),
    .lt        (x_lt_y),
    .unordered (unordered)
  );

`ifdef FP_SWAP_DESCEND_EN
  assign swap_cond = x_lt_y;
`else
  assign swap_cond = x_gt_y;
`endif

  // State register; an asynchronous reset abandons any operation in flight.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, whatever order the blocks evaluate in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and memory strobes decoded purely from state and
  // registered operands, so no input reaches an output combinationally.
  // NOTE: every output gets a default before the case; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_ra    = '0;
    mem_we    = 1'b0;
    mem_wa    = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RD_X;
      end
      RD_X: begin
        mem_re    = 1'b1;
        mem_ra    = addr_x_q;
        state_nxt = RD_Y;
      end
      RD_Y: begin
        mem_re    = 1'b1;
        mem_ra    = addr_y_q;
        state_nxt = CAP_Y;
      end
      CAP_Y: state_nxt = CMP;
      CMP:   state_nxt = swap_cond ? WR_X : DONE;
      WR_X: begin
        mem_we    = 1'b1;
        mem_wa    = addr_x_q;
        mem_wdata = opy;
        state_nxt = WR_Y;
      end
      WR_Y: begin
        mem_we    = 1'b1;
        mem_wa    = addr_y_q;
        mem_wdata = opx;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address latch, operand capture from the registered read port, and the
  // sticky result flags that hold until the next accepted start.
  // NOTE: the operand holders are plain registers, not a memory array, so
  // they are reset along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_x_q <= '0;
      addr_y_q <= '0;
      opx      <= '0;
      opy      <= '0;
      swapped  <= 1'b0;
      nan_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_x_q <= addr_x;
            addr_y_q <= addr_y;
            swapped  <= 1'b0;
            nan_flag <= 1'b0;
          end
        end
        RD_Y:  opx <= mem_rdata;  // data for the RD_X read
        CAP_Y: opy <= mem_rdata;  // data for the RD_Y read
        CMP: begin
          swapped  <= swap_cond;
          nan_flag <= unordered;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_cmp_swap_engine.sv
// Self-checking bench for fp_cmp_swap_engine. The bench owns the float
// memory, keeps an expected image of it, and predicts each operation from
// sign/magnitude float ordering; a negedge process checks the DUT strobes
// every cycle against that prediction.
module tb_fp_cmp_swap_engine;

`ifdef FP_SWAP_DESCEND_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  addr_x;
  logic [4:0]  addr_y;
  logic        busy;
  logic        done;
  logic        swapped;
  logic        nan_flag;
  logic [4:0]  mem_ra;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [4:0]  mem_wa;
  logic        mem_we;
  logic [31:0] mem_wdata;

  // Bench-side memory and preload port
  logic [31:0] mem [32];
  logic [31:0] exp_mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  int n_checks;
  int n_fail;

  // Current operation as seen by the model
  bit          op_active;
  int          op_k;
  int          op_len;
  logic [4:0]  op_x;
  logic [4:0]  op_y;
  logic [31:0] op_vx;
  logic [31:0] op_vy;
  bit          op_swap;
  bit          op_nan;
  int          re_cnt;
  int          we_cnt;
  int          done_cnt;
  int          done_k;
  bit          exp_re;
  bit          exp_we;

  fp_cmp_swap_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .addr_x    (addr_x),
    .addr_y    (addr_y),
    .busy      (busy),
    .done      (done),
    .swapped   (swapped),
    .nan_flag  (nan_flag),
    .mem_ra    (mem_ra),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_wa    (mem_wa),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-write, registered-read memory
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_wa] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_ra];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // -1 / 0 / +1 for a <, ==, > b using sign and magnitude
  function automatic int fcmp(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 0;
    if (a[31] != b[31]) return a[31] ? -1 : 1;
    if (a[30:0] == b[30:0]) return 0;
    if (!a[31]) return (a[30:0] > b[30:0]) ? 1 : -1;
    return (a[30:0] > b[30:0]) ? -1 : 1;
  endfunction

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1;
    pre_we     = 1'b0;
    exp_mem[a] = d;
  endtask

  // Runs one operation. pulse_busy re-asserts start while busy;
  // abort_k > 0 pulls reset in that cycle of the operation.
  task automatic run_op(input logic [4:0] x, input logic [4:0] y,
                        input bit pulse_busy, input int abort_k);
    int c;
    op_x    = x;
    op_y    = y;
    op_vx   = exp_mem[x];
    op_vy   = exp_mem[y];
    op_nan  = is_nan(op_vx) || is_nan(op_vy);
    c       = fcmp(op_vx, op_vy);
    op_swap = !op_nan && (DESC ? (c < 0) : (c > 0));
    op_len  = op_swap ? 7 : 5;
    re_cnt = 0; we_cnt = 0; done_cnt = 0; done_k = 0;

    @(negedge clk);
    addr_x = x;
    addr_y = y;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    op_k      = 1;
    op_active = 1'b1;
    while (op_k < op_len) begin
      start  = pulse_busy;
      addr_x = ~x;
      addr_y = ~y;
      if (abort_k > 0 && op_k == abort_k) begin
        #5;  // just past the negedge check of this cycle
        op_active = 1'b0;
        start     = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("abort_we",      {31'd0, mem_we},  32'd0);
        check("abort_busy",    {31'd0, busy},    32'd0);
        check("abort_swapped", {31'd0, swapped}, 32'd0);
        check("abort_wa",      {27'd0, mem_wa},  32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_mem_x", mem[x], exp_mem[x]);
        check("abort_mem_y", mem[y], exp_mem[y]);
        check("abort_state_idle", {31'd0, busy}, 32'd0);
        return;
      end
      @(posedge clk);
      #1;
      op_k++;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    op_active = 1'b0;

    if (op_swap) begin
      exp_mem[x] = op_vy;
      exp_mem[y] = op_vx;
    end
    check("mem_x_after", mem[x], exp_mem[x]);
    check("mem_y_after", mem[y], exp_mem[y]);
    check("done_count", done_cnt, 32'd1);
    check("read_count", re_cnt, 32'd2);
    check("write_count", we_cnt, op_swap ? 32'd2 : 32'd0);
  endtask

  // Per-cycle comparison of DUT strobes against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (!op_active) begin
        check("idle_busy", {31'd0, busy},   32'd0);
        check("idle_done", {31'd0, done},   32'd0);
        check("idle_re",   {31'd0, mem_re}, 32'd0);
        check("idle_we",   {31'd0, mem_we}, 32'd0);
      end else begin
        exp_re = (op_k == 1) || (op_k == 2);
        exp_we = op_swap && ((op_k == 5) || (op_k == 6));
        check("busy",   {31'd0, busy},   {31'd0, op_k <= op_len});
        check("done",   {31'd0, done},   {31'd0, op_k == op_len});
        check("mem_re", {31'd0, mem_re}, {31'd0, exp_re});
        check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        if (exp_re) check("mem_ra", {27'd0, mem_ra}, {27'd0, (op_k == 1) ? op_x : op_y});
        if (exp_we) begin
          check("mem_wa",    {27'd0, mem_wa}, {27'd0, (op_k == 5) ? op_x : op_y});
          check("mem_wdata", mem_wdata, (op_k == 5) ? op_vy : op_vx);
        end
        if (op_k == op_len) begin
          check("swapped",  {31'd0, swapped},  {31'd0, op_swap});
          check("nan_flag", {31'd0, nan_flag}, {31'd0, op_nan});
        end
        if (mem_re) re_cnt++;
        if (mem_we) we_cnt++;
        if (done) begin
          done_cnt++;
          done_k = op_k;
        end
      end
    end
  end

  initial begin
    logic [4:0] ab_x;
    logic [4:0] ab_y;
    n_checks  = 0;
    n_fail    = 0;
    op_active = 1'b0;
    op_k      = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    addr_x    = '0;
    addr_y    = '0;
    pre_we    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;

    #3;
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_swapped",  {31'd0, swapped},  32'd0);
    check("rst_nan",      {31'd0, nan_flag}, 32'd0);
    check("rst_re",       {31'd0, mem_re},   32'd0);
    check("rst_we",       {31'd0, mem_we},   32'd0);
    check("rst_ra",       {27'd0, mem_ra},   32'd0);
    check("rst_wa",       {27'd0, mem_wa},   32'd0);
    check("rst_wdata",    mem_wdata,         32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) poke(i[4:0], 32'd0);

    // 6.25 vs -1.5
    poke(5'd1, 32'h40C8_0000);
    poke(5'd2, 32'hBFC0_0000);
    run_op(5'd1, 5'd2, 1'b0, 0);
    check("lit_op1_mem1", mem[1], DESC ? 32'h40C8_0000 : 32'hBFC0_0000);
    check("lit_op1_mem2", mem[2], DESC ? 32'hBFC0_0000 : 32'h40C8_0000);
    check("lit_op1_swapped", {31'd0, swapped}, DESC ? 32'd0 : 32'd1);
    check("lit_op1_done_cycle", done_k, DESC ? 32'd5 : 32'd7);

    // 4.75 vs next float up
    poke(5'd3, 32'h4098_0000);
    poke(5'd4, 32'h4098_0001);
    run_op(5'd3, 5'd4, 1'b0, 0);
    check("lit_op2_mem3", mem[3], DESC ? 32'h4098_0001 : 32'h4098_0000);
    check("lit_op2_done_cycle", done_k, DESC ? 32'd7 : 32'd5);

    // -0 vs +0: equal in either order
    poke(5'd5, 32'h8000_0000);
    poke(5'd6, 32'h0000_0000);
    run_op(5'd5, 5'd6, 1'b0, 0);
    check("lit_zero_swapped", {31'd0, swapped}, 32'd0);
    run_op(5'd6, 5'd5, 1'b0, 0);

    // NaN against +0
    poke(5'd7, 32'h7FC0_0000);
    run_op(5'd7, 5'd6, 1'b0, 0);
    check("lit_nan_flag", {31'd0, nan_flag}, 32'd1);
    check("lit_nan_mem7", mem[7], 32'h7FC0_0000);

    // Same address, with start pulsed throughout the busy window
    poke(5'd3, 32'h4098_0000);
    run_op(5'd3, 5'd3, 1'b1, 0);
    check("lit_same_done_cycle", done_k, 32'd5);
    check("lit_same_nan_cleared", {31'd0, nan_flag}, 32'd0);

    // Infinities and negative pairs
    poke(5'd8,  32'h7F80_0000);
    poke(5'd9,  32'hFF80_0000);
    poke(5'd10, 32'hC000_0000);
    poke(5'd11, 32'hBF80_0000);
    run_op(5'd8,  5'd9,  1'b0, 0);
    run_op(5'd10, 5'd11, 1'b0, 0);
    run_op(5'd11, 5'd10, 1'b1, 0);

    // 4.75 at x=3 against 6.25 at y=1
    poke(5'd1, 32'h40C8_0000);
    poke(5'd3, 32'h4098_0000);
    run_op(5'd3, 5'd1, 1'b0, 0);
    check("lit_desc_mem3", mem[3], DESC ? 32'h40C8_0000 : 32'h4098_0000);
    check("lit_desc_swapped", {31'd0, swapped}, DESC ? 32'd1 : 32'd0);

    // Reset during WR_X of a swapping operation
    poke(5'd1, 32'h40C8_0000);
    poke(5'd2, 32'hBFC0_0000);
    ab_x = DESC ? 5'd2 : 5'd1;
    ab_y = DESC ? 5'd1 : 5'd2;
    run_op(ab_x, ab_y, 1'b0, 5);
    check("lit_abort_mem1", mem[1], 32'h40C8_0000);
    check("lit_abort_mem2", mem[2], 32'hBFC0_0000);

    // Recovery after the abort
    run_op(ab_x, ab_y, 1'b0, 0);
    check("lit_recover_mem1", mem[1], 32'hBFC0_0000);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_cmp_swap_engine.md
Name: fp_cmp_swap_engine

Overview:
- Initiator-side controller for the 32x32 float register memory (synchronous 1-cycle read port, synchronous write port).
- On `start`, reads two IEEE-754 single-precision words at `addr_x` and `addr_y`.
- Compares them in ascending order and, if x > y, writes them back swapped.
- Building block for an in-memory float sorter; drives the memory's write address/enable/data and read address/enable, consumes its registered read data.

Parameters:
- AW, 5, memory address width (32 words)
- DW, 32, data width (IEEE-754 single)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse, sampled only in IDLE
- addr_x  input  AW  first operand address, latched on accepted start
- addr_y  input  AW  second operand address, latched on accepted start
- busy  output  1  high from the cycle after start is accepted until DONE exits
- done  output  1  one-cycle completion pulse
- swapped  output  1  result of last op: 1 = words exchanged; held until next accepted start
- nan_flag  output  1  last op saw a NaN operand; held until next accepted start
- mem_ra  output  AW  read address (to memory a2)
- mem_re  output  1  read enable (to memory re)
- mem_rdata  input  DW  registered read data (from memory data_out), valid the cycle after mem_re
- mem_wa  output  AW  write address (to memory a1)
- mem_we  output  1  write enable (to memory we)
- mem_wdata  output  DW  write data (to memory data_in)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - busy, done, swapped, nan_flag, mem_re and mem_we are 0.
  - mem_ra, mem_wa and mem_wdata are 0.
  - Operand and address registers cleared.
  - Reset mid-operation aborts immediately; no further writes are issued.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs.
- States and transitions:
  - IDLE: if start=1, latch addr_x/addr_y, clear swapped/nan_flag, go to RD_X. start in any other state is ignored.
  - RD_X: mem_re=1, mem_ra=x. Go to RD_Y.
  - RD_Y: mem_re=1, mem_ra=y. Capture mem_rdata into opx. Go to CAP_Y.
  - CAP_Y: capture mem_rdata into opy. Go to CMP.
  - CMP: evaluate the order. If the swap condition holds, set swapped=1 and go to WR_X; otherwise go to DONE.
  - WR_X: mem_we=1, mem_wa=x, mem_wdata=opy. Go to WR_Y.
  - WR_Y: mem_we=1, mem_wa=y, mem_wdata=opx. Go to DONE.
  - DONE: done=1. Go to IDLE.
- Latency, counting from the edge where start is sampled:
  - No swap: done is high in cycle 5.
  - Swap: done is high in cycle 7.
  - A back-to-back start is accepted on the edge after DONE.
- Order rule (ascending, swap when x > y):
  - NaN is exp=0xFF with mantissa != 0. If either operand is NaN: nan_flag=1, no swap.
  - ±0 compare equal: both magnitudes (bits[30:0]) zero means no swap.
  - Otherwise form key = sign ? ~bits : bits | 0x80000000 and compare keys unsigned. Equal keys mean no swap.
  - ±Inf are ordered naturally.
- addr_x == addr_y: the reads still occur; CMP never swaps (the keys are equal).
- mem_re and mem_we are never both high in the same cycle.

Optional Feature:
- Macro: FP_SWAP_DESCEND_EN.
- Defined: the swap condition inverts to x < y (descending order). NaN and ±0 rules are unchanged.
- Undefined: ascending order as above.

Decomposition:
- Package fp_mem_pkg holds:
  - State enum (IDLE, RD_X, RD_Y, CAP_Y, CMP, WR_X, WR_Y, DONE).
  - FP field constants: EXP_MSB=30, EXP_LSB=23, MAN_W=23, EXP_ALL1=8'hFF.
  - Default AW/DW.
- One combinational sub-module, fp_order_cmp, takes a, b and outputs gt, lt, unordered. It is reusable by a future full sorter.

Test Plan:
- mem[1]=0x40C80000 (6.25), mem[2]=0xBFC00000 (-1.5), start x=1,y=2 -> writes mem[1]=0xBFC00000, mem[2]=0x40C80000; swapped=1; done in cycle 7.
- mem[3]=0x40980000 (4.75), mem[4]=0x40980001, x=3,y=4 -> no writes; swapped=0; done in cycle 5.
- mem[5]=0x80000000 (-0), mem[6]=0x00000000, x=5,y=6 -> no swap. Then mem[7]=0x7FC00000 (NaN) against mem[6] -> nan_flag=1, no writes.
- start x=y=3 -> exactly 2 reads, 0 writes, done in cycle 5. start pulses while busy -> ignored; exactly one done pulse.
- rst_n low during WR_X -> mem_we drops to 0 asynchronously, no WR_Y write, busy=0, state IDLE.
- With FP_SWAP_DESCEND_EN defined: 4.75 at x=3 and 6.25 at x=1, run x=3,y=1 -> swapped=1, mem[3]=0x40C80000.
